noc_vc_link_arbiter: RTL and testbench

NOC_VC_LINK_ARBITER -- requirements
Module: noc_vc_link_arbiter

---
 rtl/noc_vc_link_arbiter.sv | 111 +++++++++++
 tb/tb_noc_vc_link_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_link_arbiter.sv
// rtl/noc_vc_link_arbiter.sv - round-robin flit arbiter for a shared VC NoC link with per-VC wormhole locks
module noc_vc_link_arbiter #(
  parameter int NumberOfRequesters      = 4,
  parameter int NumberOfVirtualChannels = 2,
  parameter int FlitWidth               = 64,
  localparam int VcW  = (NumberOfVirtualChannels > 1) ? $clog2(NumberOfVirtualChannels) : 1,
  localparam int ReqW = (NumberOfRequesters > 1) ? $clog2(NumberOfRequesters) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NumberOfRequesters-1:0]           req_valid,
  output logic [NumberOfRequesters-1:0]           req_ready,
  input  logic [NumberOfRequesters*FlitWidth-1:0] req_flit,
  input  logic [NumberOfRequesters*VcW-1:0]       req_vc,
  input  logic [NumberOfRequesters-1:0]           req_tail,
  input  logic [NumberOfVirtualChannels-1:0]      avail,
  output logic                                    valid,
  output logic [VcW-1:0]                          vc,
  output logic [FlitWidth-1:0]                    flit
);

  logic [ReqW-1:0]                    rr_ptr;
  logic [NumberOfVirtualChannels-1:0] vc_locked;
  logic [ReqW-1:0]                    vc_owner [NumberOfVirtualChannels];

  logic [NumberOfRequesters-1:0] elig;
  logic [NumberOfRequesters-1:0] gnt;
  logic                          found;
  logic [ReqW-1:0]               win;
  logic [ReqW:0]                 sum;
  logic [VcW-1:0]                win_vc;
  logic [FlitWidth-1:0]          win_flit;
  logic                          win_tail;

  // An out-of-range VC index matches no v below, so such a requester is never eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumberOfRequesters; i++) begin
      for (int v = 0; v < NumberOfVirtualChannels; v++) begin
        if (req_valid[i] && (req_vc[i*VcW +: VcW] == VcW'(v)) && avail[v] &&
            (!vc_locked[v] || (vc_owner[v] == ReqW'(i)))) begin
          elig[i] = 1'b1;
        end
      end
    end
  end

  // Search upward from rr_ptr with wrap-around; first eligible requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NumberOfRequesters; k++) begin
      sum = {1'b0, rr_ptr} + (ReqW+1)'(k);
      if (sum >= (ReqW+1)'(NumberOfRequesters)) begin
        sum = sum - (ReqW+1)'(NumberOfRequesters);
      end
      if (!found && elig[sum[ReqW-1:0]]) begin
        found = 1'b1;
        win   = sum[ReqW-1:0];
      end
    end
    if (found) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    win_vc   = '0;
    win_flit = '0;
    win_tail = 1'b0;
    for (int i = 0; i < NumberOfRequesters; i++) begin
      if (gnt[i]) begin
        win_vc   = req_vc[i*VcW +: VcW];
        win_flit = req_flit[i*FlitWidth +: FlitWidth];
        win_tail = req_tail[i];
      end
    end
  end

  assign req_ready = rst_n ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      vc        <= '0;
      flit      <= '0;
      rr_ptr    <= '0;
      vc_locked <= '0;
      for (int v = 0; v < NumberOfVirtualChannels; v++) begin
        vc_owner[v] <= '0;
      end
    end else begin
      valid <= found;
      if (found) begin
        vc     <= win_vc;
        flit   <= win_flit;
        rr_ptr <= (win == ReqW'(NumberOfRequesters - 1)) ? '0 : win + ReqW'(1);
        // Head/body flits lock the VC to the winner; a tail flit releases it.
        for (int v = 0; v < NumberOfVirtualChannels; v++) begin
          if (win_vc == VcW'(v)) begin
            vc_locked[v] <= !win_tail;
            vc_owner[v]  <= win;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_link_arbiter.sv
// tb/tb_noc_vc_link_arbiter.sv - directed self-checking bench for noc_vc_link_arbiter
module tb_noc_vc_link_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [255:0] req_flit;
  logic [3:0]  req_vc;
  logic [3:0]  req_tail;
  logic [1:0]  avail;
  logic        valid;
  logic [0:0]  vc;
  logic [63:0] flit;

  logic [3:0]  req_valid3;
  logic [3:0]  req_ready3;
  logic [31:0] req_flit3;
  logic [7:0]  req_vc3;
  logic [3:0]  req_tail3;
  logic [2:0]  avail3;
  logic        valid3;
  logic [1:0]  vc3;
  logic [7:0]  flit3;

  int checks = 0;
  int errors = 0;

  noc_vc_link_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_flit(req_flit), .req_vc(req_vc), .req_tail(req_tail), .avail(avail),
    .valid(valid), .vc(vc), .flit(flit)
  );

  noc_vc_link_arbiter #(.NumberOfRequesters(4), .NumberOfVirtualChannels(3), .FlitWidth(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_flit(req_flit3), .req_vc(req_vc3), .req_tail(req_tail3), .avail(avail3),
    .valid(valid3), .vc(vc3), .flit(flit3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the combinational grant, clock once, then check the registered link.
  task automatic step(input string tag, input logic [3:0] er, input logic ev,
                      input logic evc, input logic [63:0] ef);
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 64'(valid), 64'(ev));
    chk({tag, ".vc"}, 64'(vc), 64'(evc));
    chk({tag, ".flit"}, flit, ef);
  endtask

  task automatic set_req(input int i, input logic v, input logic c, input logic t);
    req_valid[i] = v;
    req_vc[i]    = c;
    req_tail[i]  = t;
  endtask

  initial begin
    logic [3:0] exp_order [5];
    int         order [5];
    order = '{0, 1, 2, 3, 0};

    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_vc     = '0;
    req_tail   = '1;
    avail      = 2'b11;
    for (int i = 0; i < 4; i++) req_flit[i*64 +: 64] = 64'hF00 + 64'(i);
    req_valid3 = '0;
    req_vc3    = '0;
    req_tail3  = '1;
    avail3     = '0;
    req_flit3  = 32'h44332211;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(req_ready), 64'h0);
    chk("rst.valid", 64'(valid), 64'h0);
    chk("rst.vc", 64'(vc), 64'h0);
    chk("rst.flit", flit, 64'h0);
    rst_n = 1'b1;

    // Four single-flit requesters on VC0: strict rotation 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      exp_order[k] = 4'b0001 << order[k];
      step("rr", exp_order[k], 1'b1, 1'b0, 64'hF00 + 64'(order[k]));
    end
    req_valid = '0;
    step("idle", 4'b0000, 1'b0, 1'b0, 64'hF00);

    // Three-flit packet from req0 on VC1 holds off req1 until after the tail.
    avail = 2'b10;
    req_flit[0 +: 64] = 64'hB0;
    set_req(0, 1'b1, 1'b1, 1'b0);
    step("pkt.h", 4'b0001, 1'b1, 1'b1, 64'hB0);
    req_flit[0 +: 64] = 64'hB1;
    set_req(1, 1'b1, 1'b1, 1'b1);
    step("pkt.b", 4'b0001, 1'b1, 1'b1, 64'hB1);
    req_flit[0 +: 64] = 64'hB2;
    set_req(0, 1'b1, 1'b1, 1'b1);
    step("pkt.t", 4'b0001, 1'b1, 1'b1, 64'hB2);
    set_req(0, 1'b0, 1'b1, 1'b1);
    step("pkt.r1", 4'b0010, 1'b1, 1'b1, 64'hF01);

    // req0 holds VC0; req1 on VC1 interleaves; req2 on VC0 stays blocked.
    req_valid = '0;
    req_flit[0 +: 64] = 64'hF00;
    avail = 2'b11;
    set_req(0, 1'b1, 1'b0, 1'b0);
    step("lk.h", 4'b0001, 1'b1, 1'b0, 64'hF00);
    set_req(1, 1'b1, 1'b1, 1'b1);
    set_req(2, 1'b1, 1'b0, 1'b1);
    step("lk.1a", 4'b0010, 1'b1, 1'b1, 64'hF01);
    step("lk.0a", 4'b0001, 1'b1, 1'b0, 64'hF00);
    step("lk.1b", 4'b0010, 1'b1, 1'b1, 64'hF01);
    set_req(1, 1'b0, 1'b1, 1'b1);
    set_req(2, 1'b0, 1'b0, 1'b1);
    set_req(0, 1'b1, 1'b0, 1'b1);
    step("lk.t", 4'b0001, 1'b1, 1'b0, 64'hF00);

    // No availability: nothing moves; then only VC0 opens.
    set_req(0, 1'b1, 1'b0, 1'b1);
    set_req(1, 1'b1, 1'b1, 1'b1);
    set_req(2, 1'b1, 1'b0, 1'b1);
    set_req(3, 1'b1, 1'b1, 1'b1);
    avail = 2'b00;
    for (int k = 0; k < 5; k++) step("noav", 4'b0000, 1'b0, 1'b0, 64'hF00);
    avail = 2'b01;
    step("av0", 4'b0100, 1'b1, 1'b0, 64'hF02);
    avail = 2'b00;
    step("av0.off", 4'b0000, 1'b0, 1'b0, 64'hF02);

    // Reset while VC0 is locked to req2.
    req_valid = '0;
    set_req(2, 1'b1, 1'b0, 1'b0);
    avail = 2'b01;
    step("rl.h", 4'b0100, 1'b1, 1'b0, 64'hF02);
    rst_n = 1'b0;
    #1;
    chk("rl.async.valid", 64'(valid), 64'h0);
    chk("rl.async.flit", flit, 64'h0);
    chk("rl.async.ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("rl.hold.valid", 64'(valid), 64'h0);
    req_valid = '0;
    rst_n = 1'b1;
    step("rl.rel", 4'b0000, 1'b0, 1'b0, 64'h0);
    set_req(1, 1'b1, 1'b0, 1'b1);
    set_req(2, 1'b1, 1'b0, 1'b0);
    step("rl.r1", 4'b0010, 1'b1, 1'b0, 64'hF01);
    req_valid = '0;

    // Out-of-range VC index (3 with three VCs) is never granted.
    req_valid3 = 4'b0011;
    req_vc3    = 8'b0000_1011;
    avail3     = 3'b111;
    #1;
    chk("oor.ready1", 64'(req_ready3), 64'h2);
    @(posedge clk);
    #1;
    chk("oor.valid1", 64'(valid3), 64'h1);
    chk("oor.vc1", 64'(vc3), 64'h2);
    chk("oor.flit1", 64'(flit3), 64'h22);
    req_valid3 = 4'b0001;
    #1;
    chk("oor.ready2", 64'(req_ready3), 64'h0);
    @(posedge clk);
    #1;
    chk("oor.valid2", 64'(valid3), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
